dcache_axi_bridge: RTL

Cache-side AXI4 master that serves dcache line refills and dirty-line writebacks. It accepts one line request at a time from the dcache (`axi_req`/`axi_rw`/`axi_req_addr`). For writebacks it buffers the 8 × 64-bit beats pushed by the cache and issues an INCR write burst. For refills it issues an INCR read burst, collects the returned line, and exposes it beat-by-beat through `axi_fifo_idx`. It sits between the dcache and the memory-side AXI interconnect.

---
 rtl/dcache_axi_bridge_if.sv | 45 ++++
 rtl/dcache_axi_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_bridge_if.sv
// Memory-side AXI4 channels used by the dcache line bridge.
// The master modport belongs to the bridge; the slave modport belongs to the interconnect/memory.
interface dcache_axi_bridge_if;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Dcache-side AXI4 master: one 8-beat line refill or dirty-line writeback at a time,
// staged through an 8-entry line buffer shared by both directions.
module dcache_axi_bridge #(
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_req,
  input  logic        axi_rw,
  input  logic [63:0] axi_req_addr,
  input  logic [63:0] axi_fifo_data_i,
  input  logic        axi_fifo_wen,
  input  logic [8:0]  axi_fifo_idx,
  input  logic        axi_fifo_done,
  output logic        axi_done,
  output logic [63:0] axi_data_o,
  output logic        axi_err,
  dcache_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_t      state_r;
  logic [63:0] line_buf_r [BEATS];
  logic [63:0] addr_r;
  logic        rw_r;
  logic [2:0]  wp_r;
  logic [2:0]  bc_r;
  logic        err_r;
  logic        done_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        wlast_r;
  logic [63:0] wdata_r;
  logic        bready_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        done_exit_s;
  logic        rd_beat_s;
  logic        push_s;
  logic [2:0]  rd_idx_s;

  assign axi.awaddr  = addr_r;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_r;
  assign axi.wdata   = wdata_r;
  assign axi.wstrb   = 8'hFF;
  assign axi.wlast   = wlast_r;
  assign axi.wvalid  = wvalid_r;
  assign axi.bready  = bready_r;
  assign axi.araddr  = addr_r;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'd3;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_r;
  assign axi_done    = done_r;
  assign axi_err     = err_r;

  // Decode of buffer write sources, DONE exit and the combinational drain index
  always_comb begin
    done_exit_s = axi_fifo_done || !axi_req || (axi_rw != rw_r);
    rd_beat_s   = (state_r == RD_DATA) && axi.rvalid && rready_r;
    push_s      = axi_fifo_wen && (state_r != RD_DATA);
    rd_idx_s    = 3'(axi_fifo_idx >> 6);
    axi_data_o  = line_buf_r[rd_idx_s];
  end

  // Line buffer storage; refill beats and cache pushes never target it in the same cycle
  always_ff @(posedge clk) begin
    if (rd_beat_s) begin
      line_buf_r[bc_r] <= axi.rdata;
    end else if (push_s) begin
      line_buf_r[wp_r] <= axi_fifo_data_i;
    end
  end

  // Writeback push pointer, rewound when the cache releases the finished line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r <= 3'd0;
    end else if ((state_r == DONE) && done_exit_s) begin
      wp_r <= 3'd0;
    end else if (push_s) begin
      wp_r <= wp_r + 3'd1;
    end
  end

  // Transaction FSM with all handshake outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      addr_r    <= 64'd0;
      rw_r      <= 1'b0;
      bc_r      <= 3'd0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      wlast_r   <= 1'b0;
      wdata_r   <= 64'd0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (axi_req) begin
            addr_r <= axi_req_addr & ~64'h3F;
            rw_r   <= axi_rw;
            err_r  <= 1'b0;
            if (axi_rw) begin
              awvalid_r <= 1'b1;
              state_r   <= WR_ADDR;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (axi.awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            bc_r      <= 3'd0;
            wdata_r   <= line_buf_r[0];
            wlast_r   <= (LAST_BEAT == 3'd0);
            state_r   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (axi.wready) begin
            bc_r <= bc_r + 3'd1;
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= WR_RESP;
            end else begin
              // Preload the next beat so payload only moves on an accepted beat
              wdata_r <= line_buf_r[bc_r + 3'd1];
              wlast_r <= ((bc_r + 3'd1) == LAST_BEAT);
            end
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_r <= 1'b0;
            done_r   <= 1'b1;
            if (axi.bresp != 2'b00) begin
              err_r <= 1'b1;
            end
            state_r <= DONE;
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            bc_r      <= 3'd0;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            bc_r <= bc_r + 3'd1;
            if (axi.rresp != 2'b00) begin
              err_r <= 1'b1;
            end
            // A missing rlast still ends the line after the last buffer slot
            if (axi.rlast || (bc_r == LAST_BEAT)) begin
              rready_r <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end
          end
        end
        DONE: begin
          if (done_exit_s) begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
